// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
//   state_e : arbiter FSM states (IDLE, EXEC, RESP)
//   ALU_*   : ALU operation codes carried on the ctrl fields
package alu_arb_pkg;

  localparam int unsigned CTRL_W  = 3;
  localparam int unsigned NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [CTRL_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [CTRL_W-1:0] ALU_PASSB = 3'b001;
  localparam logic [CTRL_W-1:0] ALU_AND   = 3'b010;
  localparam logic [CTRL_W-1:0] ALU_OR    = 3'b011;
  localparam logic [CTRL_W-1:0] ALU_SLT   = 3'b101;

  // One-hot response-valid pattern for a given owner index.
  function automatic logic [NUM_REQ-1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of all requester, response and ALU-side signals of alu_arbiter.
//   slave  : view taken by the arbiter
//   master : view taken by requesters / responders / ALU
interface alu_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_op1;
  logic [DATA_WIDTH-1:0] req0_op2;
  logic [2:0]            req0_ctrl;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_op1;
  logic [DATA_WIDTH-1:0] req1_op2;
  logic [2:0]            req1_ctrl;

  logic                  rsp0_valid;
  logic                  rsp0_ready;
  logic [DATA_WIDTH-1:0] rsp0_result;
  logic                  rsp0_zero;

  logic                  rsp1_valid;
  logic                  rsp1_ready;
  logic [DATA_WIDTH-1:0] rsp1_result;
  logic                  rsp1_zero;

  logic [DATA_WIDTH-1:0] alu_op1;
  logic [DATA_WIDTH-1:0] alu_op2;
  logic [2:0]            alu_ctrl;
  logic [DATA_WIDTH-1:0] alu_sum;
  logic                  alu_zero;

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_ctrl,
    input  req1_valid, req1_op1, req1_op2, req1_ctrl,
    input  rsp0_ready, rsp1_ready,
    input  alu_sum, alu_zero,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero,
    output rsp1_valid, rsp1_result, rsp1_zero,
    output alu_op1, alu_op2, alu_ctrl
  );

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_ctrl,
    output req1_valid, req1_op1, req1_op2, req1_ctrl,
    output rsp0_ready, rsp1_ready,
    output alu_sum, alu_zero,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero,
    input  rsp1_valid, rsp1_result, rsp1_zero,
    input  alu_op1, alu_op2, alu_ctrl
  );

endinterface

// File: rtl/alu_arb_alu.sv
// Combinational ALU shared by the arbiter's requesters.
//   op1, op2 : operands
//   ctrl     : operation code (ALU_*), unknown codes produce 0
//   sum      : result
//   zero     : operand-equality flag (op1 == op2), used for branch compares
module alu_arb_alu
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [CTRL_W-1:0]     ctrl,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  zero
);

  logic slt;

  assign slt  = ($signed(op1) < $signed(op2));
  assign zero = (op1 == op2);

  always_comb begin
    sum = '0;
    case (ctrl)
      ALU_ADD:   sum = op1 + op2;
      ALU_PASSB: sum = op2;
      ALU_AND:   sum = op1 & op2;
      ALU_OR:    sum = op1 | op2;
      ALU_SLT:   sum = DATA_WIDTH'(slt);
      default:   sum = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: the requester named by ptr wins when valid,
// otherwise the other one wins if valid.
//   valid[1:0] : request vector
//   ptr        : preferred requester index
//   grant[1:0] : one-hot grant (all zero when nobody is valid)
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (valid[ptr]) begin
      grant[ptr] = 1'b1;
    end else if (valid[~ptr]) begin
      grant[~ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters.
// Sequence per operation: IDLE (grant/accept) -> EXEC (capture ALU) -> RESP
// (hold response until the owner's rsp ready). Fairness is round robin: after
// each completed response the pointer moves to the non-owner.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requester, response and ALU-side signals (slave view)
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus
);

  state_e                state_q, state_n;
  logic                  ptr_q;
  logic                  owner_q;
  logic [DATA_WIDTH-1:0] op1_q, op2_q;
  logic [CTRL_W-1:0]     ctrl_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] result0_q, result1_q;
  logic                  zero0_q, zero1_q;

  logic [NUM_REQ-1:0]    valid_vec;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    ready_c;
  logic                  accept_c;
  logic                  done_c;
  logic                  owner_ready;

  logic [DATA_WIDTH-1:0] sel_op1, sel_op2;
  logic [CTRL_W-1:0]     sel_ctrl;

  assign valid_vec = {bus.req1_valid, bus.req0_valid};

  rr_arbiter2 u_rr (
    .valid (valid_vec),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // Operand mux driven by the winning grant.
  assign sel_op1  = grant[1] ? bus.req1_op1  : bus.req0_op1;
  assign sel_op2  = grant[1] ? bus.req1_op2  : bus.req0_op2;
  assign sel_ctrl = grant[1] ? bus.req1_ctrl : bus.req0_ctrl;

  assign owner_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

  // Next-state and handshake decode; ready is only offered in IDLE outside reset.
  always_comb begin
    state_n  = state_q;
    ready_c  = '0;
    accept_c = 1'b0;
    done_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst) begin
          ready_c = grant;
          if (|grant) begin
            accept_c = 1'b1;
            state_n  = EXEC;
          end
        end
      end
      EXEC: state_n = RESP;
      RESP: begin
        if (owner_ready) begin
          done_c  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Operand, owner, pointer and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      ctrl_q      <= '0;
      rsp_valid_q <= '0;
      result0_q   <= '0;
      result1_q   <= '0;
      zero0_q     <= 1'b0;
      zero1_q     <= 1'b0;
    end else begin
      if (accept_c) begin
        op1_q   <= sel_op1;
        op2_q   <= sel_op2;
        ctrl_q  <= sel_ctrl;
        owner_q <= grant[1];
      end
      // Capture into the owner's slot; the non-owner slot is cleared so it reads 0.
      if (state_q == EXEC) begin
        rsp_valid_q <= owner_onehot(owner_q);
        if (owner_q) begin
          result0_q <= '0;
          zero0_q   <= 1'b0;
          result1_q <= bus.alu_sum;
          zero1_q   <= bus.alu_zero;
        end else begin
          result0_q <= bus.alu_sum;
          zero0_q   <= bus.alu_zero;
          result1_q <= '0;
          zero1_q   <= 1'b0;
        end
      end
      if (done_c) begin
        rsp_valid_q <= '0;
        ptr_q       <= ~owner_q;
      end
    end
  end

  assign bus.req0_ready  = ready_c[0];
  assign bus.req1_ready  = ready_c[1];

  assign bus.rsp0_valid  = rsp_valid_q[0];
  assign bus.rsp1_valid  = rsp_valid_q[1];
  assign bus.rsp0_result = result0_q;
  assign bus.rsp1_result = result1_q;
  assign bus.rsp0_zero   = zero0_q;
  assign bus.rsp1_zero   = zero1_q;

  assign bus.alu_op1     = op1_q;
  assign bus.alu_op2     = op2_q;
  assign bus.alu_ctrl    = ctrl_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with the real ALU on the alu_* side.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int unsigned DW = 32;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  alu_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  alu_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_arb_alu #(.DATA_WIDTH(DW)) u_alu (
    .op1  (bus.alu_op1),
    .op2  (bus.alu_op2),
    .ctrl (bus.alu_ctrl),
    .sum  (bus.alu_sum),
    .zero (bus.alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_op1 = '0; bus.req0_op2 = '0; bus.req0_ctrl = '0;
    bus.req1_valid = 1'b0; bus.req1_op1 = '0; bus.req1_op2 = '0; bus.req1_ctrl = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;

    // Reset state, with a request already pending.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_ctrl = ALU_ADD; bus.req0_op1 = 32'd5; bus.req0_op2 = 32'd7;
    #1;
    check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    check("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("rst_alu_op1", bus.alu_op1, 32'd0);
    check("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    check("rst_rsp0_result", bus.rsp0_result, 32'd0);

    // req0 ADD 5+7, accepted on the first edge after reset release.
    @(negedge clk);
    rst = 1'b0; bus.rsp0_ready = 1'b1;
    #1;
    check("add_req0_ready", 32'(bus.req0_ready), 32'd1);
    check("add_req1_ready", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    check("add_exec_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("add_alu_op1", bus.alu_op1, 32'd5);
    check("add_alu_op2", bus.alu_op2, 32'd7);
    check("add_alu_sum", bus.alu_sum, 32'd12);
    @(negedge clk);
    #1;
    check("add_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    check("add_rsp0_result", bus.rsp0_result, 32'd12);
    check("add_rsp0_zero", 32'(bus.rsp0_zero), 32'd0);
    check("add_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    check("add_rsp1_result", bus.rsp1_result, 32'd0);

    // req1 ADD 0x10+0x10 -> 0x20, zero flag set (equal operands).
    @(negedge clk);
    bus.req1_valid = 1'b1; bus.req1_ctrl = ALU_ADD; bus.req1_op1 = 32'h10; bus.req1_op2 = 32'h10;
    bus.rsp1_ready = 1'b1;
    #1;
    check("eq_rsp0_valid_done", 32'(bus.rsp0_valid), 32'd0);
    check("eq_alu_op1_hold", bus.alu_op1, 32'd5);
    check("eq_req1_ready", 32'(bus.req1_ready), 32'd1);
    check("eq_req0_ready", 32'(bus.req0_ready), 32'd0);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    #1;
    check("eq_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
    check("eq_rsp1_result", bus.rsp1_result, 32'h20);
    check("eq_rsp1_zero", 32'(bus.rsp1_zero), 32'd1);
    check("eq_rsp0_result", bus.rsp0_result, 32'd0);

    // Reset pulse, then both valid together: req0 first, then req1.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("both_rst_alu_op1", bus.alu_op1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_ctrl = ALU_ADD; bus.req0_op1 = 32'd1; bus.req0_op2 = 32'd2;
    bus.req1_valid = 1'b1; bus.req1_ctrl = ALU_SLT; bus.req1_op1 = 32'd3; bus.req1_op2 = 32'd9;
    #1;
    check("both_req0_ready", 32'(bus.req0_ready), 32'd1);
    check("both_req1_ready", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    check("both_exec_req1_ready", 32'(bus.req1_ready), 32'd0);
    check("both_exec_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    @(negedge clk);
    #1;
    check("both_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    check("both_rsp0_result", bus.rsp0_result, 32'd3);
    check("both_rsp1_valid_first", 32'(bus.rsp1_valid), 32'd0);
    @(negedge clk);
    #1;
    check("both_req1_ready", 32'(bus.req1_ready), 32'd1);
    check("both_rsp0_valid_done", 32'(bus.rsp0_valid), 32'd0);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    #1;
    check("both_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
    check("both_rsp1_result", bus.rsp1_result, 32'd1);
    check("both_rsp1_zero", 32'(bus.rsp1_zero), 32'd0);

    // Backpressure: rsp0_ready low for 4 RESP cycles while req1 waits.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_ctrl = ALU_ADD; bus.req0_op1 = 32'd20; bus.req0_op2 = 32'd22;
    bus.req1_valid = 1'b1; bus.req1_ctrl = ALU_PASSB; bus.req1_op1 = 32'd1; bus.req1_op2 = 32'd99;
    bus.rsp0_ready = 1'b0;
    #1;
    check("bp_req0_ready", 32'(bus.req0_ready), 32'd1);
    check("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("bp_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
      check("bp_rsp0_result", bus.rsp0_result, 32'd42);
      check("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
    end
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_rsp0_valid_done", 32'(bus.rsp0_valid), 32'd0);
    check("bp_req1_ready_after", 32'(bus.req1_ready), 32'd1);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    #1;
    check("bp_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
    check("bp_rsp1_result", bus.rsp1_result, 32'd99);

    // Reset during EXEC aborts the operation; a fresh req0 then completes.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_ctrl = ALU_ADD; bus.req0_op1 = 32'd4; bus.req0_op2 = 32'd4;
    #1;
    check("abort_req0_ready", 32'(bus.req0_ready), 32'd1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("abort_alu_op1", bus.alu_op1, 32'd0);
    check("abort_rsp0_result", bus.rsp0_result, 32'd0);
    @(negedge clk);
    #1;
    check("abort_rsp0_valid_hold", 32'(bus.rsp0_valid), 32'd0);
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op1 = 32'd8; bus.req0_op2 = 32'd9;
    bus.req1_valid = 1'b1;
    #1;
    check("abort_ptr0_req0_ready", 32'(bus.req0_ready), 32'd1);
    check("abort_ptr0_req1_ready", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
    #1;
    check("abort_new_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    check("abort_new_rsp0_result", bus.rsp0_result, 32'd17);
    check("abort_new_rsp0_zero", 32'(bus.rsp0_zero), 32'd0);

    // Continuous valid on both requesters: grants alternate every 3 cycles.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_ctrl = ALU_ADD; bus.req0_op1 = 32'd2;    bus.req0_op2 = 32'd3;
    bus.req1_valid = 1'b1; bus.req1_ctrl = ALU_OR;  bus.req1_op1 = 32'h0F;  bus.req1_op2 = 32'hF0;
    for (int c = 0; c < 12; c++) begin
      logic [1:0] exp_onehot;
      exp_onehot = (((c / 3) % 2) != 0) ? 2'b10 : 2'b01;
      #1;
      check("rr_grant", 32'({bus.req1_ready, bus.req0_ready}),
            (c % 3 == 0) ? 32'(exp_onehot) : 32'd0);
      check("rr_rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}),
            (c % 3 == 2) ? 32'(exp_onehot) : 32'd0);
      if (c % 3 == 2) begin
        check("rr_rsp_result", exp_onehot[1] ? bus.rsp1_result : bus.rsp0_result,
              exp_onehot[1] ? 32'hFF : 32'd5);
      end
      @(negedge clk);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    #1;
    check("rr_end_idle_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the operand/result width.
REQ-002 SHALL have port clk, input, 1 bit, the single clock.
REQ-003 SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-004 SHALL have, per requester i in {0,1}: reqi_valid in 1, reqi_ready out 1, reqi_op1 in DATA_WIDTH, reqi_op2 in DATA_WIDTH, reqi_ctrl in 3 (ALU op code).
REQ-005 SHALL have, per requester i: rspi_valid out 1, rspi_ready in 1, rspi_result out DATA_WIDTH, rspi_zero out 1.
REQ-006 SHALL have ALU-side ports: alu_op1 out DATA_WIDTH, alu_op2 out DATA_WIDTH, alu_ctrl out 3, alu_sum in DATA_WIDTH, alu_zero in 1.

Function
REQ-007 SHALL share one combinational ALU between two requesters via FSM states IDLE, EXEC, RESP.
REQ-008 IDLE: reqi_ready SHALL equal 1 only for the requester granted by the round-robin pointer among those with reqi_valid=1; all other ready outputs 0.
REQ-009 Accept: a request SHALL be accepted on the edge where reqi_valid and reqi_ready are both 1; op1/op2/ctrl and the owner index are latched; next state EXEC.
REQ-010 IDLE with no valid request: SHALL remain in IDLE, all ready outputs 0.
REQ-011 Both valid in IDLE: SHALL grant the requester indicated by the pointer; the pointer's value at reset is 0.
REQ-012 EXEC: SHALL capture alu_sum and alu_zero into result registers; next state RESP; exactly one cycle.
REQ-013 RESP: rspi_valid SHALL be 1 only for the owner; rspi_result/rspi_zero hold the captured values, stable until handshake.
REQ-014 RESP with rspi_ready=0: SHALL stay in RESP indefinitely (backpressure), with no new accept.
REQ-015 RESP with rspi_ready=1: SHALL complete the transfer, set the pointer to the non-owner, and return to IDLE.
REQ-016 Latency: SHALL raise rspi_valid exactly 2 cycles after the accept edge; peak throughput is 1 op per 3 cycles.
REQ-017 alu_op1/alu_op2/alu_ctrl SHALL be driven from the latched operand registers at all times (hold the last values in IDLE/RESP).
REQ-018 ctrl codes SHALL pass through unmodified; undefined codes (100, 110, 111) are not filtered and the ALU default applies.
REQ-019 rspi_result/rspi_zero of the non-owner SHALL read 0.
REQ-020 A requester deasserting reqi_valid before accept SHALL not be recorded.

Reset
REQ-021 While rst=1: state IDLE, pointer 0, operand/result/owner registers 0, all reqi_ready and rspi_valid 0, alu_* outputs 0.
REQ-022 rst asserted in EXEC or RESP SHALL abort the in-flight operation with no response emitted; operation resumes from IDLE after release.
REQ-023 The first accept SHALL be possible on the first clk edge after rst deasserts.

Structure
REQ-024 Package alu_arb_pkg SHALL hold the state enum (IDLE, EXEC, RESP) and ALU op constants ALU_ADD=000, ALU_PASSB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101.
REQ-025 A sub-module rr_arbiter2 (2-way round-robin: valid[1:0], pointer -> one-hot grant) SHALL be used; the FSM and registers stay in alu_arbiter.
REQ-026 The bench SHALL instantiate the real ALU connected to alu_* ports.

Verification
REQ-027 req0 add op1=5, op2=7, rsp0_ready=1 -> rsp0_valid 2 cycles after accept, rsp0_result=12, rsp0_zero=0.
REQ-028 req0 and req1 valid same cycle after reset (req0 ADD 1,2; req1 SLT 3,9) -> req0 served first (result 3), then req1 (result 1); rsp1 never precedes rsp0.
REQ-029 req1 ADD op1=op2=0x10 -> rsp1_result=0x20, rsp1_zero=1.
REQ-030 rsp0_ready held 0 for 4 cycles in RESP -> rsp0_valid stays 1, result stable, req1_ready=0 throughout; accept of a waiting req1 occurs the cycle after the handshake.
REQ-031 rst pulsed during EXEC of req0 -> no rsp0_valid, all outputs 0, pointer 0; a new req0 after release completes normally.
REQ-032 Continuous valid on both requesters for 12 cycles -> grants alternate 0,1,0,1, one accept per 3 cycles.
